microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Next-address controller for the microprogrammed ARM control unit.
- Holds the microprogram address register that indexes the 128-entry x 45-bit microstore ROM.
- Each cycle it picks the next microaddress from: increment, branch target, instruction-decoder entry, fetch entry, or conditional/MOC-wait variants.
- Inputs are the sequencing fields of the current control word plus datapath status. It sits between the microstore ROM, the instruction decoder and the memory interface.

Parameters:
- ADDR_W, 7, microaddress width (ROM depth 2**ADDR_W).
- RESET_ADDR, 7'd0, microaddress loaded on reset.
- FETCH_ADDR, 7'd1, entry of the instruction-fetch microroutine.
- ABORT_ADDR, 7'd0, target on MOC timeout.
- MOC_TIMEOUT, 16, maximum WAIT_MOC cycles before abort; 0 disables the watchdog.
- STACK_DEPTH, 4, return-stack entries (used only with the optional feature).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- ns, input, 3: next-state select field of the current control word.
- cond_sel, input, 2: condition select. 00 = moc, 01 = cond_true, 10 = ext_cond, 11 = constant 1.
- inv, input, 1: invert the selected condition.
- br_addr, input, ADDR_W: branch/call target field of the control word.
- dec_addr, input, ADDR_W: microroutine entry address from the instruction decoder.
- moc, input, 1: memory operation complete.
- cond_true, input, 1: ARM condition-code evaluation result for the current instruction.
- ext_cond, input, 1: auxiliary test input (e.g. shifter/ALU status).
- stall, input, 1: freeze the sequencer.
- uaddr, output, ADDR_W: registered microaddress; drives the ROM index.
- waiting, output, 1: current microinstruction is WAIT_MOC and moc = 0.
- moc_timeout, output, 1: one-cycle pulse when the watchdog aborts.
- stack_err, output, 1: sticky stack overflow/underflow flag (driven 0 when the feature is off).

Behaviour:
- Reset (sync, highest priority): uaddr = RESET_ADDR, watchdog count = 0, moc_timeout = 0, stack pointer = 0, stack_err = 0.
  - A reset mid-wait or mid-subroutine discards all state.
- Timing: the ROM is combinational. Fields ns, cond_sel, inv and br_addr belong to the word at the current uaddr. Next address is computed combinationally and registered on the next rising edge, giving 1 cycle per microinstruction.
- Condition: c = (selected input) XOR inv.
- Next-address select (ns):
  - 000 INC: uaddr+1, modulo 2**ADDR_W (127 wraps to 0, no flag).
  - 001 JUMP: br_addr.
  - 010 DECODE: dec_addr.
  - 011 FETCH: FETCH_ADDR.
  - 100 BRC: c ? br_addr : uaddr+1.
  - 101 WAIT_MOC: moc ? uaddr+1 : uaddr (hold).
  - 110 CALL: see Optional Feature; treated as JUMP without it.
  - 111 RET: see Optional Feature; treated as FETCH without it.
- Watchdog:
  - The counter increments each cycle uaddr is held in WAIT_MOC with moc = 0, and clears on any address change.
  - When the count reaches MOC_TIMEOUT - 1 and moc is still 0, the next uaddr is ABORT_ADDR. In that same edge moc_timeout = 1 for exactly one cycle and the counter clears.
  - If moc = 1 in the same cycle the limit is reached, moc wins (INC, no pulse).
- stall = 1:
  - uaddr, counter and stack are held; moc_timeout = 0.
  - waiting still reflects the current word.
  - Priority: reset > stall > ns decode.

Optional Feature:
- Macro: MICROSEQ_STACK_EN.
- Defined:
  - STACK_DEPTH-entry LIFO return stack.
  - CALL pushes uaddr+1 and goes to br_addr.
  - RET pops and goes to the popped value.
  - CALL when full: target is still taken, push is dropped, stack_err is set.
  - RET when empty: goes to FETCH_ADDR, stack_err is set.
  - stack_err clears only on reset.
- Undefined: no stack storage; CALL = JUMP, RET = FETCH, stack_err tied to 0.

Decomposition:
- Shared package microseq_pkg holds:
  - ns encodings (NS_INC … NS_RET);
  - cond_sel encodings;
  - ADDR_W default;
  - FETCH_ADDR / RESET_ADDR constants, so the microstore contents and the sequencer agree.
- One natural sub-module, microseq_stack: LIFO with push, pop, full, empty and sticky error. It is instantiated only under MICROSEQ_STACK_EN.

Test Plan:
- Reset, then ns = INC for 3 cycles: uaddr goes 0 → 1 → 2 → 3. Set uaddr = 127 with INC: next uaddr = 0.
- BRC, cond_sel = 01, br_addr = 7'h40: with cond_true = 1 → 7'h40. With cond_true = 0, inv = 0 → uaddr+1. With inv = 1 → 7'h40.
- WAIT_MOC at uaddr = 7'h52, moc low for 5 cycles then high: uaddr holds 7'h52 for 5 cycles with waiting = 1, then 7'h53, waiting = 0.
- MOC_TIMEOUT = 4, moc stuck low at WAIT_MOC: after 4 cycles uaddr = ABORT_ADDR, moc_timeout pulses for exactly 1 cycle. Repeat with moc rising on the 4th cycle: uaddr+1, no pulse.
- stall high during DECODE with dec_addr = 7'h2B: uaddr frozen. Release stall: uaddr = 7'h2B next edge. Reset asserted during WAIT_MOC: uaddr = 0 and counter cleared.
- With MICROSEQ_STACK_EN, STACK_DEPTH = 4:
  - CALL at 7'h10 to 7'h30, then RET → 7'h11.
  - 5 nested CALLs → stack_err = 1, 5th push dropped.
  - RET on empty stack → FETCH_ADDR, stack_err = 1.

Source files
------------

// File: rtl/microseq_pkg.sv
// microseq_pkg -- shared definitions for the microprogram sequencer.
//
// Holds the next-state (ns) and condition-select encodings of the control
// word, the default microaddress width, and the fixed entry points. The
// microstore image and the sequencer both use these, so they cannot drift
// apart. A small helper evaluates the selected branch condition.
//
// Optional feature macro (used by the importing files): MICROSEQ_STACK_EN.

package microseq_pkg;

  // Default microaddress width: 128-entry microstore.
  localparam int unsigned ADDR_W_DEF = 7;

  // Fixed microroutine entry points.
  localparam logic [6:0] RESET_ADDR_DEF = 7'd0;
  localparam logic [6:0] FETCH_ADDR_DEF = 7'd1;
  localparam logic [6:0] ABORT_ADDR_DEF = 7'd0;

  // Next-state select field of the control word.
  typedef enum logic [2:0] {
    NS_INC      = 3'b000,
    NS_JUMP     = 3'b001,
    NS_DECODE   = 3'b010,
    NS_FETCH    = 3'b011,
    NS_BRC      = 3'b100,
    NS_WAIT_MOC = 3'b101,
    NS_CALL     = 3'b110,
    NS_RET      = 3'b111
  } ns_e;

  // Condition select field of the control word.
  typedef enum logic [1:0] {
    COND_MOC  = 2'b00,
    COND_TRUE = 2'b01,
    COND_EXT  = 2'b10,
    COND_ONE  = 2'b11
  } cond_sel_e;

  // Selected condition, optionally inverted.
  function automatic logic cond_eval(
    input logic [1:0] sel,
    input logic       moc,
    input logic       cond_true,
    input logic       ext_cond,
    input logic       inv
  );
    logic s;
    case (cond_sel_e'(sel))
      COND_MOC:  s = moc;
      COND_TRUE: s = cond_true;
      COND_EXT:  s = ext_cond;
      default:   s = 1'b1;
    endcase
    return s ^ inv;
  endfunction

endpackage

// File: rtl/microseq_stack.sv
// microseq_stack -- LIFO return-address stack for microroutine CALL/RET.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high; empties the stack, clears err
//   push       store push_data on top (dropped when full)
//   pop        discard the top entry (no-op when empty)
//   push_data  return address to store
//   top_data   current top entry (valid only when !empty)
//   full       DEPTH entries held
//   empty      no entries held
//   err        sticky: set by push-when-full or pop-when-empty, cleared by reset
//
// push and pop are mutually exclusive by construction in the sequencer.
// Only instantiated when MICROSEQ_STACK_EN is defined.

module microseq_stack
  import microseq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = ADDR_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty,
  output logic         err
);

  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] top_idx;

  always_comb begin
    full     = (sp == SP_W'(DEPTH));
    empty    = (sp == '0);
    // Index is forced to 0 when empty so the read never leaves the array.
    top_idx  = empty ? '0 : IDX_W'(sp - 1'b1);
    top_data = mem[top_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp  <= '0;
      err <= 1'b0;
    end else if (push) begin
      if (full) err <= 1'b1;
      else      sp  <= sp + 1'b1;
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else       sp  <= sp - 1'b1;
    end
  end

  // Storage carries no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push && !full) mem[IDX_W'(sp)] <= push_data;
  end

endmodule

// File: rtl/microsequencer.sv
// microsequencer -- next-address controller for the microprogrammed control
// unit. Owns the microprogram address register that indexes the microstore.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high; uaddr = RESET_ADDR, all state cleared
//   ns           next-state select of the current control word
//   cond_sel     condition select (moc / cond_true / ext_cond / 1)
//   inv          invert the selected condition
//   br_addr      branch / call target of the current control word
//   dec_addr     microroutine entry from the instruction decoder
//   moc          memory operation complete
//   cond_true    condition-code evaluation for the current instruction
//   ext_cond     auxiliary test input
//   stall        freeze uaddr, watchdog and stack
//   uaddr        registered microaddress (microstore index)
//   waiting      current word is WAIT_MOC and moc is low
//   moc_timeout  one-cycle pulse when the watchdog forces ABORT_ADDR
//   stack_err    sticky return-stack overflow/underflow (0 without the stack)
//
// Optional feature macro: MICROSEQ_STACK_EN. When defined, CALL/RET use a
// STACK_DEPTH-entry return stack; otherwise CALL acts as JUMP, RET as FETCH.
// MOC_TIMEOUT = 0 disables the watchdog.

module microsequencer
  import microseq_pkg::*;
#(
  parameter int unsigned       ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(RESET_ADDR_DEF),
  parameter logic [ADDR_W-1:0] FETCH_ADDR  = ADDR_W'(FETCH_ADDR_DEF),
  parameter logic [ADDR_W-1:0] ABORT_ADDR  = ADDR_W'(ABORT_ADDR_DEF),
  parameter int unsigned       MOC_TIMEOUT = 16,
  parameter int unsigned       STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        ns,
  input  logic [1:0]        cond_sel,
  input  logic              inv,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic              moc,
  input  logic              cond_true,
  input  logic              ext_cond,
  input  logic              stall,
  output logic [ADDR_W-1:0] uaddr,
  output logic              waiting,
  output logic              moc_timeout,
  output logic              stack_err
);

  localparam bit          WD_EN    = (MOC_TIMEOUT != 0);
  localparam int unsigned CNT_W    = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LIMIT =
    (MOC_TIMEOUT > 0) ? CNT_W'(MOC_TIMEOUT - 1) : '0;

  logic [ADDR_W-1:0] inc_addr;
  logic [ADDR_W-1:0] nxt_addr;
  logic [CNT_W-1:0]  wd_cnt;
  logic [CNT_W-1:0]  wd_cnt_nxt;
  logic              wd_hit;
  logic              cond;

`ifdef MICROSEQ_STACK_EN
  logic              push_req;
  logic              pop_req;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full;
  logic              stk_empty;
  logic              stk_err;

  microseq_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req & ~stall),
    .pop       (pop_req & ~stall),
    .push_data (inc_addr),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .err       (stk_err)
  );
`endif

  assign inc_addr = uaddr + 1'b1;
  assign cond     = cond_eval(cond_sel, moc, cond_true, ext_cond, inv);

  // State register: reset > stall > normal sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      uaddr       <= RESET_ADDR;
      wd_cnt      <= '0;
      moc_timeout <= 1'b0;
    end else if (stall) begin
      moc_timeout <= 1'b0;
    end else begin
      uaddr       <= nxt_addr;
      wd_cnt      <= wd_cnt_nxt;
      moc_timeout <= wd_hit;
    end
  end

  // Next-address and watchdog computation. The counter only survives a cycle
  // in which WAIT_MOC holds the address; every other path clears it.
  always_comb begin
    nxt_addr   = inc_addr;
    wd_cnt_nxt = '0;
    wd_hit     = 1'b0;
`ifdef MICROSEQ_STACK_EN
    push_req   = 1'b0;
    pop_req    = 1'b0;
`endif
    case (ns_e'(ns))
      NS_INC:    nxt_addr = inc_addr;
      NS_JUMP:   nxt_addr = br_addr;
      NS_DECODE: nxt_addr = dec_addr;
      NS_FETCH:  nxt_addr = FETCH_ADDR;
      NS_BRC:    nxt_addr = cond ? br_addr : inc_addr;
      NS_WAIT_MOC: begin
        if (moc) begin
          nxt_addr = inc_addr;
        end else if (WD_EN && (wd_cnt == WD_LIMIT)) begin
          nxt_addr = ABORT_ADDR;
          wd_hit   = 1'b1;
        end else begin
          nxt_addr   = uaddr;
          wd_cnt_nxt = WD_EN ? wd_cnt + 1'b1 : '0;
        end
      end
      NS_CALL: begin
        nxt_addr = br_addr;
`ifdef MICROSEQ_STACK_EN
        push_req = 1'b1;
`endif
      end
      NS_RET: begin
`ifdef MICROSEQ_STACK_EN
        pop_req  = 1'b1;
        nxt_addr = stk_empty ? FETCH_ADDR : stk_top;
`else
        nxt_addr = FETCH_ADDR;
`endif
      end
      default: nxt_addr = inc_addr;
    endcase
  end

  // Outputs derived from the current word.
  always_comb begin
    waiting = (ns_e'(ns) == NS_WAIT_MOC) && !moc;
`ifdef MICROSEQ_STACK_EN
    stack_err = stk_err;
`else
    stack_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer -- directed scoreboard bench for microsequencer.
// The bench plays the role of the microstore: each step drives the fields of
// the word at the current uaddr and queues the hand-computed result. A
// monitor checks waiting mid-cycle and uaddr/moc_timeout/stack_err just after
// the following rising edge. Two instances share stimulus: dut (watchdog 16)
// and dut_wd (watchdog 4); each queued vector names the instance it checks.

module tb_microsequencer;
  import microseq_pkg::*;

`ifdef MICROSEQ_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ns = 3'b000;
  logic [1:0] cond_sel = 2'b00;
  logic       inv = 1'b0;
  logic [6:0] br_addr = '0;
  logic [6:0] dec_addr = '0;
  logic       moc = 1'b0;
  logic       cond_true = 1'b0;
  logic       ext_cond = 1'b0;
  logic       stall = 1'b0;

  logic [6:0] u0, u1;
  logic       w0, w1, t0, t1, e0, e1;

  always #5 clk = ~clk;

  microsequencer #(.MOC_TIMEOUT(16), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ns(ns), .cond_sel(cond_sel), .inv(inv),
    .br_addr(br_addr), .dec_addr(dec_addr), .moc(moc), .cond_true(cond_true),
    .ext_cond(ext_cond), .stall(stall), .uaddr(u0), .waiting(w0),
    .moc_timeout(t0), .stack_err(e0)
  );

  microsequencer #(.MOC_TIMEOUT(4), .STACK_DEPTH(4)) dut_wd (
    .clk(clk), .reset(reset), .ns(ns), .cond_sel(cond_sel), .inv(inv),
    .br_addr(br_addr), .dec_addr(dec_addr), .moc(moc), .cond_true(cond_true),
    .ext_cond(ext_cond), .stall(stall), .uaddr(u1), .waiting(w1),
    .moc_timeout(t1), .stack_err(e1)
  );

  typedef struct packed {
    logic       which;
    logic [6:0] eu;
    logic       ew;
    logic       et;
    logic       ee;
  } exp_t;

  exp_t  eq[$];
  string nq[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic step(input string nm, input logic which, input logic rst,
                      input logic stl, input logic [2:0] f_ns,
                      input logic [1:0] cs, input logic iv,
                      input logic [6:0] br, input logic [6:0] dec,
                      input logic m, input logic ct, input logic ex,
                      input logic [6:0] eu, input logic ew, input logic et,
                      input logic ee);
    exp_t e;
    @(posedge clk);
    #2;
    reset = rst; stall = stl; ns = f_ns; cond_sel = cs; inv = iv;
    br_addr = br; dec_addr = dec; moc = m; cond_true = ct; ext_cond = ex;
    e.which = which; e.eu = eu; e.ew = ew; e.et = et; e.ee = ee;
    eq.push_back(e);
    nq.push_back(nm);
  endtask

  // Monitor / scoreboard.
  initial begin
    exp_t  e;
    string nm;
    logic [6:0] au;
    logic aw, at, ae;
    forever begin
      @(negedge clk);
      if (eq.size() > 0) begin
        e  = eq.pop_front();
        nm = nq.pop_front();
        n_vec++;
        aw = e.which ? w1 : w0;
        if (aw !== e.ew) begin
          n_err++;
          $display("FAIL %s waiting: got %b want %b", nm, aw, e.ew);
        end
        @(posedge clk);
        #1;
        au = e.which ? u1 : u0;
        at = e.which ? t1 : t0;
        ae = e.which ? e1 : e0;
        if (au !== e.eu) begin
          n_err++;
          $display("FAIL %s uaddr: got %h want %h", nm, au, e.eu);
        end
        if (at !== e.et) begin
          n_err++;
          $display("FAIL %s moc_timeout: got %b want %b", nm, at, e.et);
        end
        if (ae !== e.ee) begin
          n_err++;
          $display("FAIL %s stack_err: got %b want %b", nm, ae, e.ee);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // name, which, rst, stall, ns, cond_sel, inv, br, dec, moc, ct, ext,
    //   exp uaddr, exp waiting, exp moc_timeout, exp stack_err
    step("rst",      0, 1, 0, NS_INC,  0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0, 0);
    step("inc1",     0, 0, 0, NS_INC,  0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h01, 0, 0, 0);
    step("inc2",     0, 0, 0, NS_INC,  0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h02, 0, 0, 0);
    step("inc3",     0, 0, 0, NS_INC,  0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h03, 0, 0, 0);
    step("jmp7f",    0, 0, 0, NS_JUMP, 0, 0, 7'h7f, 7'h00, 0, 0, 0, 7'h7f, 0, 0, 0);
    step("wrap",     0, 0, 0, NS_INC,  0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0, 0);
    step("jmp10",    0, 0, 0, NS_JUMP, 0, 0, 7'h10, 7'h00, 0, 0, 0, 7'h10, 0, 0, 0);
    step("brc_t",    0, 0, 0, NS_BRC,  1, 0, 7'h40, 7'h00, 0, 1, 0, 7'h40, 0, 0, 0);
    step("jmp10b",   0, 0, 0, NS_JUMP, 0, 0, 7'h10, 7'h00, 0, 0, 0, 7'h10, 0, 0, 0);
    step("brc_f",    0, 0, 0, NS_BRC,  1, 0, 7'h40, 7'h00, 0, 0, 0, 7'h11, 0, 0, 0);
    step("brc_inv",  0, 0, 0, NS_BRC,  1, 1, 7'h40, 7'h00, 0, 0, 0, 7'h40, 0, 0, 0);
    step("brc_one",  0, 0, 0, NS_BRC,  3, 1, 7'h05, 7'h00, 0, 1, 1, 7'h41, 0, 0, 0);
    step("brc_ext",  0, 0, 0, NS_BRC,  2, 0, 7'h05, 7'h00, 0, 0, 1, 7'h05, 0, 0, 0);
    step("brc_moc",  0, 0, 0, NS_BRC,  0, 0, 7'h22, 7'h00, 1, 0, 0, 7'h22, 0, 0, 0);
    step("jmp52",    0, 0, 0, NS_JUMP, 0, 0, 7'h52, 7'h00, 0, 0, 0, 7'h52, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step("wait_hold", 0, 0, 0, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h52, 1, 0, 0);
    step("wait_done",0, 0, 0, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 1, 0, 0, 7'h53, 0, 0, 0);
    step("dec_stl1", 0, 0, 1, NS_DECODE, 0, 0, 7'h00, 7'h2b, 0, 0, 0, 7'h53, 0, 0, 0);
    step("dec_stl2", 0, 0, 1, NS_DECODE, 0, 0, 7'h00, 7'h2b, 0, 0, 0, 7'h53, 0, 0, 0);
    step("dec_go",   0, 0, 0, NS_DECODE, 0, 0, 7'h00, 7'h2b, 0, 0, 0, 7'h2b, 0, 0, 0);
    step("fetch",    0, 0, 0, NS_FETCH,  0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h01, 0, 0, 0);
    step("jmp52b",   0, 0, 0, NS_JUMP, 0, 0, 7'h52, 7'h00, 0, 0, 0, 7'h52, 0, 0, 0);
    step("wait_stl", 0, 0, 1, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h52, 1, 0, 0);
    // Subroutine call / return.
    step("jmp10c",   0, 0, 0, NS_JUMP, 0, 0, 7'h10, 7'h00, 0, 0, 0, 7'h10, 0, 0, 0);
    step("call30",   0, 0, 0, NS_CALL, 0, 0, 7'h30, 7'h00, 0, 0, 0, 7'h30, 0, 0, 0);
    step("ret",      0, 0, 0, NS_RET,  0, 0, 7'h00, 7'h00, 0, 0, 0, STK ? 7'h11 : 7'h01, 0, 0, 0);
    step("call_n1",  0, 0, 0, NS_CALL, 0, 0, 7'h60, 7'h00, 0, 0, 0, 7'h60, 0, 0, 0);
    step("call_n2",  0, 0, 0, NS_CALL, 0, 0, 7'h61, 7'h00, 0, 0, 0, 7'h61, 0, 0, 0);
    step("call_n3",  0, 0, 0, NS_CALL, 0, 0, 7'h62, 7'h00, 0, 0, 0, 7'h62, 0, 0, 0);
    step("call_n4",  0, 0, 0, NS_CALL, 0, 0, 7'h63, 7'h00, 0, 0, 0, 7'h63, 0, 0, 0);
    step("call_ovf", 0, 0, 0, NS_CALL, 0, 0, 7'h64, 7'h00, 0, 0, 0, 7'h64, 0, 0, STK);
    step("ret_n4",   0, 0, 0, NS_RET,  0, 0, 7'h00, 7'h00, 0, 0, 0, STK ? 7'h63 : 7'h01, 0, 0, STK);
    step("ret_n3",   0, 0, 0, NS_RET,  0, 0, 7'h00, 7'h00, 0, 0, 0, STK ? 7'h62 : 7'h01, 0, 0, STK);
    step("ret_n2",   0, 0, 0, NS_RET,  0, 0, 7'h00, 7'h00, 0, 0, 0, STK ? 7'h61 : 7'h01, 0, 0, STK);
    step("ret_n1",   0, 0, 0, NS_RET,  0, 0, 7'h00, 7'h00, 0, 0, 0, STK ? 7'h12 : 7'h01, 0, 0, STK);
    step("ret_unf",  0, 0, 0, NS_RET,  0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h01, 0, 0, STK);
    step("rst2",     0, 1, 0, NS_INC,  0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0, 0);
    step("ret_empty",0, 0, 0, NS_RET,  0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h01, 0, 0, STK);
    step("err_stick",0, 0, 0, NS_INC,  0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h02, 0, 0, STK);

    // Watchdog, MOC_TIMEOUT = 4.
    step("wd_rst",   1, 1, 0, NS_INC,  0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0, 0);
    step("wd_jmp",   1, 0, 0, NS_JUMP, 0, 0, 7'h52, 7'h00, 0, 0, 0, 7'h52, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("wd_hold", 1, 0, 0, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h52, 1, 0, 0);
    step("wd_abort", 1, 0, 0, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 1, 1, 0);
    step("wd_pulse1",1, 0, 0, NS_INC,  0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h01, 0, 0, 0);
    step("wd_jmp2",  1, 0, 0, NS_JUMP, 0, 0, 7'h52, 7'h00, 0, 0, 0, 7'h52, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("wd_hold2", 1, 0, 0, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h52, 1, 0, 0);
    step("wd_mocwin",1, 0, 0, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 1, 0, 0, 7'h53, 0, 0, 0);
    step("wd_jmp3",  1, 0, 0, NS_JUMP, 0, 0, 7'h52, 7'h00, 0, 0, 0, 7'h52, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      step("wd_hold3", 1, 0, 0, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h52, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step("wd_stall", 1, 0, 1, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h52, 1, 0, 0);
    step("wd_hold3b",1, 0, 0, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h52, 1, 0, 0);
    step("wd_abort3",1, 0, 0, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 1, 1, 0);
    step("wd_jmp4",  1, 0, 0, NS_JUMP, 0, 0, 7'h52, 7'h00, 0, 0, 0, 7'h52, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      step("wd_hold4", 1, 0, 0, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h52, 1, 0, 0);
    step("wd_rstmid",1, 1, 0, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step("wd_clr",   1, 0, 0, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 1, 0, 0);
    step("wd_abort4",1, 0, 0, NS_WAIT_MOC, 0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 1, 1, 0);
    step("wd_idle",  1, 0, 0, NS_INC,  0, 0, 7'h00, 7'h00, 0, 0, 0, 7'h01, 0, 0, 0);

    repeat (2) @(posedge clk);
    #3;
    if (eq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", eq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
